// File: rtl/ast_arb_pkg.sv
// rtl/ast_arb_pkg.sv - shared state type and width constants for the packet arbiter
package ast_arb_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int DROP_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/ast_packet_arbiter_if.sv
// rtl/ast_packet_arbiter_if.sv - two Avalon-ST sinks, one source, control and status of the arbiter
interface ast_packet_arbiter_if #(
  parameter int DATA_WIDTH = ast_arb_pkg::DATA_WIDTH_DEF
);
  import ast_arb_pkg::*;

  logic [DATA_WIDTH-1:0] din0_data;
  logic                  din0_startofpacket;
  logic                  din0_endofpacket;
  logic                  din0_valid;
  logic                  din0_ready;
  logic [DATA_WIDTH-1:0] din1_data;
  logic                  din1_startofpacket;
  logic                  din1_endofpacket;
  logic                  din1_valid;
  logic                  din1_ready;
  logic [DATA_WIDTH-1:0] dout_data;
  logic                  dout_startofpacket;
  logic                  dout_endofpacket;
  logic                  dout_valid;
  logic                  dout_ready;
  logic                  enable;
  logic [1:0]            grant;
  logic [DROP_W-1:0]     drop_count;

  modport slave (
    input  din0_data, din0_startofpacket, din0_endofpacket, din0_valid,
    input  din1_data, din1_startofpacket, din1_endofpacket, din1_valid,
    input  dout_ready, enable,
    output din0_ready, din1_ready,
    output dout_data, dout_startofpacket, dout_endofpacket, dout_valid,
    output grant, drop_count
  );

  modport master (
    output din0_data, din0_startofpacket, din0_endofpacket, din0_valid,
    output din1_data, din1_startofpacket, din1_endofpacket, din1_valid,
    output dout_ready, enable,
    input  din0_ready, din1_ready,
    input  dout_data, dout_startofpacket, dout_endofpacket, dout_valid,
    input  grant, drop_count
  );

endinterface

// File: rtl/ast_sat_counter.sv
// rtl/ast_sat_counter.sv - counter that adds 0..2 per cycle and sticks at all-ones
module ast_sat_counter
  import ast_arb_pkg::*;
#(
  parameter int WIDTH = DROP_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH:0] sum;

  // One spare bit is enough: the largest sum is all-ones plus two.
  assign sum = {1'b0, count} + {{(WIDTH-1){1'b0}}, inc};

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (sum[WIDTH]) begin
      count <= '1;
    end else begin
      count <= sum[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/ast_packet_arbiter.sv
// rtl/ast_packet_arbiter.sv - round-robin packet arbiter merging two Avalon-ST streams into one
module ast_packet_arbiter
  import ast_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic               clock,
  input  logic               reset,
  ast_packet_arbiter_if.slave bus
);

  arb_state_t state, state_next, state_eff;
  logic owner, owner_next, last_owner, last_owner_next;
  logic cand0, cand1, orphan0, orphan1;
  logic ready0, ready1, sel_valid, sel_sop, sel_eop;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [1:0] grant, drop_inc;
  logic [DROP_W-1:0] drop_count;

  // While reset is held the outputs already behave as IDLE.
  assign state_eff = reset ? IDLE : state;
  assign cand0     = bus.enable & bus.din0_valid & bus.din0_startofpacket;
  assign cand1     = bus.enable & bus.din1_valid & bus.din1_startofpacket;
  assign orphan0   = bus.din0_valid & ~bus.din0_startofpacket;
  assign orphan1   = bus.din1_valid & ~bus.din1_startofpacket;

  always_comb begin
    state_next      = state_eff;
    owner_next      = owner;
    last_owner_next = last_owner;
    ready0          = 1'b0;
    ready1          = 1'b0;
    sel_valid       = 1'b0;
    sel_sop         = 1'b0;
    sel_eop         = 1'b0;
    sel_data        = '0;
    grant           = 2'b00;
    drop_inc        = 2'd0;
    case (state_eff)
      IDLE: begin
        // Mid-packet beats with no owner are swallowed; sop beats wait for a grant.
        ready0   = orphan0;
        ready1   = orphan1;
        drop_inc = {1'b0, orphan0} + {1'b0, orphan1};
        if (cand0 && cand1) begin
          owner_next = ~last_owner;
          state_next = BUSY;
        end else if (cand0 || cand1) begin
          owner_next = cand1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (owner) begin
          sel_valid = bus.din1_valid;
          sel_sop   = bus.din1_startofpacket;
          sel_eop   = bus.din1_endofpacket;
          sel_data  = bus.din1_data;
          ready1    = bus.dout_ready;
          grant     = 2'b10;
        end else begin
          sel_valid = bus.din0_valid;
          sel_sop   = bus.din0_startofpacket;
          sel_eop   = bus.din0_endofpacket;
          sel_data  = bus.din0_data;
          ready0    = bus.dout_ready;
          grant     = 2'b01;
        end
        if (sel_valid && bus.dout_ready && sel_eop) begin
          last_owner_next = owner;
          state_next      = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
    end else begin
      state      <= state_next;
      owner      <= owner_next;
      last_owner <= last_owner_next;
    end
  end

  ast_sat_counter #(.WIDTH(DROP_W)) u_drop_counter (
    .clock (clock),
    .reset (reset),
    .inc   (drop_inc),
    .count (drop_count)
  );

  assign bus.din0_ready         = ready0;
  assign bus.din1_ready         = ready1;
  assign bus.dout_valid         = sel_valid;
  assign bus.dout_startofpacket = sel_sop;
  assign bus.dout_endofpacket   = sel_eop;
  assign bus.dout_data          = sel_data;
  assign bus.grant              = grant;
  assign bus.drop_count         = drop_count;

endmodule

// File: tb/tb_ast_packet_arbiter.sv
// tb/tb_ast_packet_arbiter.sv - directed and randomized checks of the packet arbiter against a cycle model
module tb_ast_packet_arbiter;

  logic clock = 1'b0;
  logic reset;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  ast_packet_arbiter_if #(.DATA_WIDTH(8)) bus ();

  ast_packet_arbiter #(.DATA_WIDTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Reference: whether a packet is open, who owns it, who had the last one, beats thrown away.
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_last  = 1;
  int m_drops = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    logic [1:0] v, s, e, exp_ready, exp_grant, cand;
    logic [7:0] d [2];
    logic exp_valid;
    int nd;
    v = {bus.din1_valid, bus.din0_valid};
    s = {bus.din1_startofpacket, bus.din0_startofpacket};
    e = {bus.din1_endofpacket, bus.din0_endofpacket};
    d[0] = bus.din0_data;
    d[1] = bus.din1_data;
    exp_ready = 2'b00;
    exp_grant = 2'b00;
    exp_valid = 1'b0;
    if (m_busy && !reset) begin
      exp_ready[m_owner] = bus.dout_ready;
      exp_grant[m_owner] = 1'b1;
      exp_valid          = v[m_owner];
    end else begin
      exp_ready = v & ~s;
    end
    check("model_ctl", {bus.grant, bus.dout_valid, bus.din1_ready, bus.din0_ready},
          {exp_grant, exp_valid, exp_ready});
    if (exp_valid)
      check("model_beat", {bus.dout_startofpacket, bus.dout_endofpacket, bus.dout_data},
            {s[m_owner], e[m_owner], d[m_owner]});
    check("model_drops", bus.drop_count, m_drops);

    if (reset) begin
      m_busy = 0; m_owner = 0; m_last = 1; m_drops = 0;
    end else if (!m_busy) begin
      nd = 0;
      for (int i = 0; i < 2; i++) if (v[i] && !s[i]) nd++;
      m_drops = (m_drops + nd > 65535) ? 65535 : m_drops + nd;
      cand = bus.enable ? (v & s) : 2'b00;
      if (cand == 2'b11) begin
        m_owner = 1 - m_last; m_busy = 1;
      end else if (cand != 2'b00) begin
        m_owner = cand[1] ? 1 : 0; m_busy = 1;
      end
    end else if (v[m_owner] && bus.dout_ready && e[m_owner]) begin
      m_last = m_owner; m_busy = 0;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input int i, input bit v, input bit s, input bit e, input logic [7:0] d);
    if (i == 0) begin
      bus.din0_valid = v; bus.din0_startofpacket = s; bus.din0_endofpacket = e; bus.din0_data = d;
    end else begin
      bus.din1_valid = v; bus.din1_startofpacket = s; bus.din1_endofpacket = e; bus.din1_data = d;
    end
  endtask

  task automatic idle_in();
    set_in(0, 0, 0, 0, 8'h00);
    set_in(1, 0, 0, 0, 8'h00);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_in();
    tick();
    reset = 1'b0;
  endtask

  int rem [2];
  bit acc [2];
  bit pat [6] = '{1, 0, 0, 1, 1, 1};

  initial begin
    int idx;
    int len;
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.dout_ready = 1'b0;
    idle_in();
    tick();

    // Single 4-beat packet on din0.
    do_reset();
    bus.enable = 1'b1;
    bus.dout_ready = 1'b1;
    #3;
    check("rst_grant", bus.grant, 2'b00);
    check("rst_valid", bus.dout_valid, 1'b0);
    check("rst_drops", bus.drop_count, 16'd0);
    tick();
    set_in(0, 1, 1, 0, 8'd10);
    #3;
    check("p1_idle_grant", bus.grant, 2'b00);
    check("p1_idle_ready", bus.din0_ready, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      set_in(0, 1, k == 0, k == 3, 8'(10 + k));
      #3;
      check("p1_data", bus.dout_data, 8'(10 + k));
      check("p1_grant", bus.grant, 2'b01);
      check("p1_framing", {bus.dout_startofpacket, bus.dout_endofpacket}, {k == 0, k == 3});
    end
    tick();
    idle_in();
    #3;
    check("p1_after_grant", bus.grant, 2'b00);

    // Simultaneous sop: din0, idle gap, din1, then din0 again.
    do_reset();
    tick();
    set_in(0, 1, 1, 0, 8'h20);
    set_in(1, 1, 1, 0, 8'h30);
    #3;
    check("tie1_wait", bus.grant, 2'b00);
    tick();
    #3;
    check("tie1_grant", bus.grant, 2'b01);
    check("tie1_data", bus.dout_data, 8'h20);
    tick();
    set_in(0, 1, 0, 1, 8'h21);
    #3;
    check("tie1_data2", bus.dout_data, 8'h21);
    check("tie1_hold1", bus.din1_ready, 1'b0);
    tick();
    set_in(0, 0, 0, 0, 8'h00);
    #3;
    check("tie1_gap", bus.grant, 2'b00);
    tick();
    #3;
    check("tie1_second", bus.grant, 2'b10);
    check("tie1_data3", bus.dout_data, 8'h30);
    tick();
    set_in(1, 1, 0, 1, 8'h31);
    #3;
    check("tie1_data4", bus.dout_data, 8'h31);
    tick();
    set_in(0, 1, 1, 1, 8'h22);
    set_in(1, 1, 1, 1, 8'h32);
    tick();
    #3;
    check("tie2_grant", bus.grant, 2'b01);
    check("tie2_data", bus.dout_data, 8'h22);
    tick();
    set_in(0, 0, 0, 0, 8'h00);
    tick();
    #3;
    check("tie2_din1", bus.grant, 2'b10);
    tick();
    idle_in();

    // Orphan beats on din1 are dropped, then a real packet passes.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      tick();
      set_in(1, 1, 0, k == 2, 8'(8'h40 + k));
      #3;
      check("orph_ready", bus.din1_ready, 1'b1);
    end
    tick();
    set_in(1, 1, 1, 0, 8'h50);
    #3;
    check("orph_count", bus.drop_count, 16'd3);
    tick();
    #3;
    check("orph_pkt0", {bus.grant, bus.dout_data}, {2'b10, 8'h50});
    tick();
    set_in(1, 1, 0, 1, 8'h51);
    #3;
    check("orph_pkt1", {bus.grant, bus.dout_data}, {2'b10, 8'h51});
    tick();
    idle_in();
    #3;
    check("orph_count_end", bus.drop_count, 16'd3);

    // Downstream backpressure inside a packet.
    do_reset();
    tick();
    set_in(0, 1, 1, 0, 8'd10);
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      bus.dout_ready = pat[c];
      set_in(0, 1, idx == 0, idx == 3, 8'(10 + idx));
      #3;
      check("bp_mirror", bus.din0_ready, pat[c]);
      check("bp_data", bus.dout_data, 8'(10 + idx));
      if (pat[c]) idx++;
    end
    tick();
    idle_in();
    bus.dout_ready = 1'b1;
    #3;
    check("bp_done", bus.grant, 2'b00);

    // enable drops mid-packet: packet finishes, next grant waits for enable.
    do_reset();
    tick();
    set_in(0, 1, 1, 0, 8'h60);
    tick();
    #3;
    check("en_grant", bus.grant, 2'b01);
    tick();
    bus.enable = 1'b0;
    set_in(0, 1, 0, 0, 8'h61);
    #3;
    check("en_keep", {bus.grant, bus.dout_data}, {2'b01, 8'h61});
    tick();
    set_in(0, 1, 0, 1, 8'h62);
    #3;
    check("en_eop", {bus.grant, bus.dout_endofpacket}, {2'b01, 1'b1});
    tick();
    set_in(0, 1, 1, 0, 8'h70);
    for (int k = 0; k < 3; k++) begin
      tick();
      #3;
      check("en_blocked", {bus.grant, bus.din0_ready}, {2'b00, 1'b0});
    end
    tick();
    bus.enable = 1'b1;
    #3;
    check("en_wait", bus.grant, 2'b00);
    tick();
    #3;
    check("en_granted", {bus.grant, bus.dout_data}, {2'b01, 8'h70});
    tick();
    set_in(0, 1, 0, 1, 8'h71);
    tick();
    idle_in();

    // Reset on beat 2 of a 5-beat packet.
    do_reset();
    tick();
    set_in(0, 1, 1, 0, 8'h80);
    tick();
    #3;
    check("rp_grant", bus.grant, 2'b01);
    tick();
    set_in(0, 1, 0, 0, 8'h81);
    tick();
    set_in(0, 1, 0, 0, 8'h82);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_in(0, 1, 0, 0, 8'h83);
    #3;
    check("rp_after", {bus.grant, bus.dout_valid, bus.din0_ready}, {2'b00, 1'b0, 1'b1});
    tick();
    set_in(0, 1, 0, 1, 8'h84);
    tick();
    idle_in();
    #3;
    check("rp_drops", bus.drop_count, 16'd2);

    // Random traffic, compared every cycle by the model.
    do_reset();
    rem[0] = 0;
    rem[1] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clock);
      acc[0] = bus.din0_valid & bus.din0_ready;
      acc[1] = bus.din1_valid & bus.din1_ready;
      tick();
      reset = ($urandom % 300 == 0);
      bus.enable = ($urandom % 8 != 0);
      bus.dout_ready = ($urandom % 4 != 0);
      for (int i = 0; i < 2; i++) begin
        if (acc[i] || !(i == 0 ? bus.din0_valid : bus.din1_valid)) begin
          if ($urandom % 4 == 0) begin
            set_in(i, 0, 0, 0, 8'h00);
          end else if (rem[i] == 0) begin
            if ($urandom % 6 == 0) begin
              set_in(i, 1, 0, 1'($urandom % 2), 8'($urandom));
            end else begin
              len = $urandom_range(1, 5);
              rem[i] = len - 1;
              set_in(i, 1, 1, len == 1, 8'($urandom));
            end
          end else begin
            rem[i]--;
            set_in(i, 1, 0, rem[i] == 0, 8'($urandom));
          end
        end
      end
    end
    reset = 1'b0;

    // Saturation: both inputs drop a beat every cycle.
    do_reset();
    bus.enable = 1'b0;
    set_in(0, 1, 0, 0, 8'h01);
    set_in(1, 1, 0, 0, 8'h02);
    repeat (32767) tick();
    #3;
    check("sat_near", bus.drop_count, 16'hFFFE);
    tick();
    #3;
    check("sat_hit", bus.drop_count, 16'hFFFF);
    repeat (3) tick();
    #3;
    check("sat_stick", bus.drop_count, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ast_packet_arbiter.md
AST_PACKET_ARBITER -- requirements
Module: ast_packet_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, on ports clock and reset.
REQ-002 Parameter DATA_WIDTH, 8, width of every data bus.
REQ-003 Port clock  input  1  single clock for all logic.
REQ-004 Port reset  input  1  synchronous active-high reset.
REQ-005 Ports din0_data / din1_data  input  DATA_WIDTH  Avalon-ST sink data, one per BT.656-to-AST converter.
REQ-006 Ports din0_startofpacket / din1_startofpacket, din0_endofpacket / din1_endofpacket, din0_valid / din1_valid  input  1  sink framing and valid.
REQ-007 Ports din0_ready / din1_ready  output  1  sink ready.
REQ-008 Ports dout_data  output  DATA_WIDTH; dout_startofpacket, dout_endofpacket, dout_valid  output  1  Avalon-ST source.
REQ-009 Port dout_ready  input  1  downstream ready.
REQ-010 Port enable  input  1  when 0, no new grant is issued.
REQ-011 Port grant  output  2  one-hot current owner: 01 = din0, 10 = din1, 00 = none.
REQ-012 Port drop_count  output  16  saturating count of discarded beats.

Function
REQ-013 State machine with two states: IDLE and BUSY; a registered owner (0/1) and a registered last_owner.
REQ-014 IDLE: dout_valid = 0; grant = 00.
REQ-015 IDLE: din_i_ready = 1 only when din_i_valid = 1 and din_i_startofpacket = 0, so that orphan mid-packet beats are discarded.
REQ-016 IDLE: a sink is a candidate when enable = 1 and it has valid = 1 and startofpacket = 1.
REQ-017 IDLE: a candidate beat is not consumed in IDLE (ready = 0).
REQ-018 IDLE with one candidate: owner <= that input, and the state moves to BUSY on the next edge.
REQ-019 IDLE with two candidates in the same cycle: owner <= NOT last_owner (round-robin).
REQ-020 BUSY: combinational pass-through from the owner; dout_data/sop/eop/valid = din_owner_*; din_owner_ready = dout_ready.
REQ-021 BUSY: the non-owner ready = 0; grant = one-hot(owner).
REQ-022 Grant latency: the first beat of a packet appears on dout exactly 1 cycle after its sop is first presented in IDLE; zero added latency thereafter.
REQ-023 BUSY: a packet ends on a handshake with endofpacket (din_owner_valid & dout_ready & din_owner_endofpacket).
REQ-024 At packet end: last_owner <= owner; state <= IDLE on the next edge, so there is one idle cycle between packets.
REQ-025 BUSY: a startofpacket received before endofpacket SHALL be passed through unchanged, with no state change.
REQ-026 BUSY: enable = 0 SHALL NOT abort the current packet; it blocks only the next grant.
REQ-027 BUSY: valid = 0 or dout_ready = 0 holds the state indefinitely, with no timeout.
REQ-028 drop_count increments by 1 on every IDLE cycle with din_i_valid & din_i_ready, for i = 0 and 1, summed; +2 if both inputs drop in the same cycle.
REQ-029 drop_count saturates at 16'hFFFF.

Reset
REQ-030 On reset: state = IDLE, owner = 0, last_owner = 1 (din0 wins the first tie), drop_count = 0.
REQ-031 Outputs during and immediately after reset: grant = 00, dout_valid = 0, din0_ready and din1_ready follow the IDLE rule.
REQ-032 Reset in mid-packet abandons the packet with no eop emitted; remaining beats of that packet are dropped as orphans.

Structure
REQ-033 Shared package ast_arb_pkg SHALL hold the state enum (IDLE, BUSY), DATA_WIDTH default, and the drop_count width constant (16).
REQ-034 One sub-module, ast_sat_counter (width parameter, increment 0..2, saturating), SHALL implement drop_count; all other logic sits in ast_packet_arbiter.

Verification
REQ-035 din0 sends a 4-beat packet (data 10,11,12,13; sop on beat 0, eop on beat 3), din1 idle, dout_ready = 1 -> dout carries 10..13 starting 1 cycle after sop, grant = 01 for 4 cycles, then 00.
REQ-036 Both inputs present sop in the same cycle right after reset -> din0 served first, then din1 after 1 idle cycle; a second simultaneous tie -> din0 served again (last_owner = din1).
REQ-037 din1 sends 3 valid non-sop beats while IDLE, then a sop packet -> drop_count = 3 and the packet passes intact.
REQ-038 dout_ready toggles 1,0,0,1 during a BUSY packet -> no beat lost or duplicated; din_owner_ready mirrors dout_ready each cycle.
REQ-039 enable = 0 asserted mid-packet -> packet completes through eop, then grant stays 00 while din0 sop waits, and it is granted 1 cycle after enable = 1.
REQ-040 Reset asserted on beat 2 of a 5-beat packet -> next cycle grant = 00, dout_valid = 0; beats 3-4 counted in drop_count (= 2).
